// File: rtl/ldm_stm_reg_sequencer_pkg.sv
// ldm_stm_reg_sequencer_pkg: shared state encodings, mux-select constants and popcount helper
package ldm_stm_reg_sequencer_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      XFER = 2'b01,
      DONE = 2'b10
   } state_t;
   localparam logic [2:0] MUX_SEL_DEFAULT = 3'b000;
   localparam logic [2:0] MUX_SEL_SEQ     = 3'b011;
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/ldm_stm_reg_sequencer_if.sv
// ldm_stm_reg_sequencer_if: request/beat bus between the LDM/STM datapath and the register sequencer
interface ldm_stm_reg_sequencer_if;
   logic        start;
   logic [15:0] reg_list;
   logic        up;
   logic        advance;
   logic        busy;
   logic        valid;
   logic [3:0]  reg_num;
   logic        last;
   logic [4:0]  count;
   logic [2:0]  mux_sel;
   logic        done;
   modport master (
      output start, reg_list, up, advance,
      input  busy, valid, reg_num, last, count, mux_sel, done
   );
   modport slave (
      input  start, reg_list, up, advance,
      output busy, valid, reg_num, last, count, mux_sel, done
   );
endinterface

// File: rtl/ldm_stm_reg_sequencer_reg_list_prio_enc.sv
// reg_list_prio_enc: bidirectional 16->4 priority encoder; lowest set bit when i_dir=1, highest otherwise
module reg_list_prio_enc (
   input  logic [15:0] i_mask,
   input  logic        i_dir,
   output logic [3:0]  o_idx,
   output logic        o_any,
   output logic        o_one_hot
);
   logic [3:0] w_lo;
   logic [3:0] w_hi;
   always_comb begin
      w_lo = '0;
      w_hi = '0;
      for (int i = 15; i >= 0; i--) w_lo = i_mask[i] ? 4'(i) : w_lo;
      for (int i = 0; i < 16; i++) w_hi = i_mask[i] ? 4'(i) : w_hi;
   end
   assign o_idx     = i_dir ? w_lo : w_hi;
   assign o_any     = |i_mask;
   assign o_one_hot = o_any && ~|(i_mask & (i_mask - 16'd1));
endmodule

// File: rtl/ldm_stm_reg_sequencer.sv
// ldm_stm_reg_sequencer: walks an LDM/STM register list, one register number per beat,
// and steers the register-file address mux to it while the transfer runs
module ldm_stm_reg_sequencer
   import ldm_stm_reg_sequencer_pkg::*;
(
   input logic                   clk,
   input logic                   reset,
   ldm_stm_reg_sequencer_if.slave bus
);
   state_t      r_state;
   logic [15:0] r_mask;
   logic        r_dir;
   logic [4:0]  r_count;
   logic [3:0]  w_idx;
   logic        w_any;
   logic        w_one_hot;
   logic        w_valid;

   reg_list_prio_enc u_enc (
      .i_mask    (r_mask),
      .i_dir     (r_dir),
      .o_idx     (w_idx),
      .o_any     (w_any),
      .o_one_hot (w_one_hot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_dir   <= 1'b1;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_mask  <= bus.reg_list;
               r_dir   <= bus.up;
               r_count <= popcount16(bus.reg_list);
               r_state <= |bus.reg_list ? XFER : DONE;
            end
            XFER: if (bus.advance) begin
               r_mask  <= r_mask & ~(16'd1 << w_idx);
               r_state <= w_one_hot ? DONE : XFER;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // mask is never empty in XFER; gating on w_any keeps mux_sel safe regardless
   assign w_valid     = (r_state == XFER) && w_any;
   assign bus.busy    = r_state != IDLE;
   assign bus.valid   = w_valid;
   assign bus.reg_num = w_valid ? w_idx : 4'd0;
   assign bus.last    = w_valid && w_one_hot;
   assign bus.count   = r_count;
   assign bus.mux_sel = w_valid ? MUX_SEL_SEQ : MUX_SEL_DEFAULT;
   assign bus.done    = r_state == DONE;
endmodule

// File: tb/tb_ldm_stm_reg_sequencer.sv
// tb_ldm_stm_reg_sequencer: directed + random stimulus checked every cycle against a queue-based model
module tb_ldm_stm_reg_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;
   int   m_phase = 0;
   int   m_count = 0;
   int   m_q[$];

   ldm_stm_reg_sequencer_if bus();

   ldm_stm_reg_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clock(input logic s, input logic [15:0] l, input logic u, input logic a, input logic r);
      if (r) begin
         m_phase = 0;
         m_count = 0;
         m_q.delete();
      end else if (m_phase == 0) begin
         if (s) begin
            m_q.delete();
            for (int n = 0; n < 16; n++)
               if (l[n]) begin
                  if (u) m_q.push_back(n);
                  else   m_q.push_front(n);
               end
            m_count = m_q.size();
            m_phase = (m_q.size() != 0) ? 1 : 2;
         end
      end else if (m_phase == 1) begin
         if (a) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = 2;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic step(input logic s, input logic [15:0] l, input logic u, input logic a, input logic r);
      int v;
      @(negedge clk);
      bus.start    = s;
      bus.reg_list = l;
      bus.up       = u;
      bus.advance  = a;
      reset        = r;
      #1;
      v = (m_phase == 1) ? 1 : 0;
      check("busy",    32'(bus.busy),    32'(m_phase != 0));
      check("valid",   32'(bus.valid),   32'(v));
      check("reg_num", 32'(bus.reg_num), v ? 32'(m_q[0]) : 32'd0);
      check("last",    32'(bus.last),    32'(v && m_q.size() == 1));
      check("count",   32'(bus.count),   32'(m_count));
      check("mux_sel", 32'(bus.mux_sel), v ? 32'd3 : 32'd0);
      check("done",    32'(bus.done),    32'(m_phase == 2));
      @(posedge clk);
      model_clock(s, l, u, a, r);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.reg_list = '0;
      bus.up = 1'b0;
      bus.advance = 1'b0;
      repeat (2) @(posedge clk);
      model_clock(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(0, 16'h0, 0, 0, 1);
      // ascending, continuous advance
      step(1, 16'h8013, 1, 1, 0);
      repeat (6) step(0, 16'h0, 0, 1, 0);
      // descending, advance every third cycle
      step(1, 16'h00F0, 0, 0, 0);
      for (int i = 0; i < 14; i++) step(0, 16'h0, 1, (i % 3) == 2, 0);
      // empty list
      step(1, 16'h0000, 1, 1, 0);
      repeat (3) step(0, 16'h0, 0, 0, 0);
      // full list
      step(1, 16'hFFFF, 1, 1, 0);
      repeat (18) step(0, 16'h0, 0, 1, 0);
      // start ignored during XFER, advance ignored in IDLE
      step(1, 16'h0006, 1, 0, 0);
      step(1, 16'hFFFF, 0, 1, 0);
      step(1, 16'hAAAA, 0, 1, 0);
      step(0, 16'h0, 0, 0, 0);
      repeat (3) step(0, 16'h0, 0, 1, 0);
      // reset mid-transfer, then a single-register list
      step(1, 16'h0F00, 1, 1, 0);
      step(0, 16'h0, 0, 0, 0);
      step(1, 16'h1234, 1, 1, 1);
      step(0, 16'h0, 0, 0, 0);
      step(1, 16'h0001, 1, 0, 0);
      step(0, 16'h0, 0, 0, 0);
      repeat (3) step(0, 16'h0, 0, 1, 0);
      for (int i = 0; i < 600; i++) begin
         logic [15:0] l;
         int k;
         k = $urandom_range(0, 9);
         l = (k == 0) ? 16'h0 : (k == 1) ? 16'hFFFF : 16'($urandom);
         step($urandom_range(0, 3) == 0, l, 1'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ldm_stm_reg_sequencer.md
# ldm_stm_reg_sequencer

Sequencer for load/store-multiple block transfers. Walks the 16-bit register list of an LDM/STM instruction and issues one 4-bit register number per transfer beat, in ascending or descending order. Sits directly upstream of the register-file address mux_8x1 (4-bit, 8:1): it drives that mux's input D with `reg_num` and its select with `mux_sel`, steering the register-file port to the sequenced register for the duration of the transfer.

## Interface
Parameters: none. Widths are fixed by the ISA: 16-register list, 4-bit register number, 3-bit mux select.

Ports:
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request to begin a transfer; honoured only in IDLE.
- `reg_list`  in  16  instruction bits [15:0]; bit n set means register n is transferred. Sampled only with an accepted `start`.
- `up`  in  1  1 = ascending order (IA/IB), 0 = descending order (DA/DB). Sampled only with an accepted `start`.
- `advance`  in  1  datapath has completed the current beat.
- `busy`  out  1  high whenever state ≠ IDLE.
- `valid`  out  1  `reg_num` is meaningful. High only in XFER.
- `reg_num`  out  4  current register number; 4'd0 when `valid` = 0.
- `last`  out  1  the current beat is the final one: `valid` and exactly one bit remains in the mask.
- `count`  out  5  population count of the accepted `reg_list` (0–16); holds until the next accepted `start`.
- `mux_sel`  out  3  3'b011 while `valid`, otherwise 3'b000.
- `done`  out  1  one-cycle pulse in state DONE.

## Operation
- State machine: IDLE, XFER, DONE. State and registers are updated synchronously; all outputs decode combinationally from state, `mask` and `dir`.
- IDLE + `start`:
  - Latch `mask` ← `reg_list`, `dir` ← `up`, and `count` ← popcount(`reg_list`).
  - Go to XFER if `reg_list` ≠ 0; otherwise go to DONE (empty-list case, no beats issued).
- XFER:
  - `reg_num` = index of the lowest set bit of `mask` if `dir` = 1, else the highest set bit.
  - On `advance`, clear that bit in `mask`. If `last` was high, go to DONE; otherwise stay in XFER with the next register.
  - Without `advance`, all outputs hold.
- DONE: `done` = 1 for one cycle, then go to IDLE. `mask` is 0 on exit.
- `start` outside IDLE is ignored. No queuing, and `count` is not disturbed.
- `advance` outside XFER is ignored.
- Reset values: state IDLE, `mask` 0, `dir` 1, `count` 0. All outputs are 0: `busy` 0, `valid` 0, `reg_num` 0, `last` 0, `count` 0, `mux_sel` 000, `done` 0.
- Reset asserted mid-transfer aborts the transfer on that edge. No `done` pulse is produced, and `reset` has priority over `start` and `advance`.

## Timing
- Cycle numbering: `start` sampled at edge k. `valid` and the first `reg_num` are available in cycle k+1.
- Throughput is one beat per cycle with `advance` held high. An N-register list with continuous `advance` gives:
  - `valid` in cycles k+1 … k+N,
  - `done` in cycle k+N+1,
  - IDLE from cycle k+N+2, where a new `start` is accepted.
- Empty list: `done` in cycle k+1 and `busy` in cycle k+1 only.
- `mux_sel` follows `valid` in the same cycle. It must never show 3'b011 while `valid` = 0.

## Structure
- The shared package/include holds:
  - state encodings: IDLE = 2'b00, XFER = 2'b01, DONE = 2'b10,
  - `MUX_SEL_DEFAULT` = 3'b000,
  - `MUX_SEL_SEQ` = 3'b011.
  These constants are reused by the control unit that drives the mux's other inputs.
- One sub-module: `reg_list_prio_enc`. It is a combinational bidirectional 16→4 priority encoder with inputs `mask` and `dir`, and outputs index, `any` and `one_hot`. The `one_hot` output drives `last`.

## Test plan
- Basic ascending: `reg_list` = 16'h8013, `up` = 1, `advance` tied high → `reg_num` 0, 1, 4, 15 on consecutive cycles; `last` on the 15 beat only; `count` = 4; `done` one cycle after the 15 beat.
- Descending with stalls: `reg_list` = 16'h00F0, `up` = 0, `advance` pulsed every third cycle → `reg_num` 7, 6, 5, 4, each held (with `valid` = 1 and `mux_sel` = 011) until its `advance`.
- Empty list: `reg_list` = 0 → `valid` never asserts; `done` in cycle k+1; `count` = 0; `mux_sel` stays 000.
- Full list: `reg_list` = 16'hFFFF, `up` = 1 → 16 beats, 0…15; `count` = 16; `last` only on 15.
- Ignored inputs: `start` asserted with a new list during XFER of 16'h0006 → sequence stays 1, 2 and `count` stays 2. `advance` asserted in IDLE → no state change.
- Reset mid-operation: `reset` during the second beat of 16'h0F00 → next cycle all outputs 0 and no `done`. A fresh `start` with 16'h0001 then yields `reg_num` 0 with `last` = 1.
